// File: rtl/image_pkg.sv
// Shared constants and state encoding for the image row packer.
package image_pkg;

  localparam int PIX_W     = 24;
  localparam int ROW_PIX   = 128;
  localparam int ROWS      = 128;
  localparam int ADDR_W    = 7;
  localparam int ROW_W     = PIX_W * ROW_PIX;
  localparam int PIX_CNT_W = $clog2(ROW_PIX);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } packer_state_t;

endpackage

// File: rtl/image_row_packer.sv
// Image row packer: gathers ROW_PIX pixels into one bank row and writes
// ROWS rows per frame, pulsing done after the last write.
// Optional end-of-line checking is enabled by defining ROW_PACKER_EOL_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting pixels into row_buf
// WRITE | single-cycle bank write of the completed row
// DONE  | single-cycle done pulse, then IDLE
module image_row_packer
  import image_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_pixel,
`ifdef ROW_PACKER_EOL_CHECK_EN
  input  logic              in_eol,
  output logic              eol_err,
`endif
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ROW_W-1:0]  wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(ROW_PIX - 1);
  localparam logic [ADDR_W-1:0]    ROW_LAST = ADDR_W'(ROWS - 1);

  packer_state_t          state_q, state_d;
  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]      row_cnt_q, row_cnt_d;
  logic [ROW_W-1:0]       row_buf_q, row_buf_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [ROW_W-1:0]       wdata_q, wdata_d;
`ifdef ROW_PACKER_EOL_CHECK_EN
  logic                   eol_err_q, eol_err_d;
`endif

  // Control outputs decode straight from the state register, so in_ready
  // never depends combinationally on in_valid.
  assign in_ready = (state_q == FILL);
  assign we       = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
`ifdef ROW_PACKER_EOL_CHECK_EN
  assign eol_err  = eol_err_q;
`endif

  // Next-state, counter, row buffer and write-port computation.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    row_cnt_d = row_cnt_q;
    row_buf_d = row_buf_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
`ifdef ROW_PACKER_EOL_CHECK_EN
    eol_err_d = eol_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FILL;
          pix_cnt_d = '0;
          row_cnt_d = '0;
`ifdef ROW_PACKER_EOL_CHECK_EN
          eol_err_d = 1'b0;
`endif
        end
      end
      FILL: begin
        if (in_valid) begin
          row_buf_d[pix_cnt_q*PIX_W +: PIX_W] = in_pixel;
`ifdef ROW_PACKER_EOL_CHECK_EN
          if (in_eol != (pix_cnt_q == PIX_LAST)) begin
            eol_err_d = 1'b1;
          end
`endif
          if (pix_cnt_q == PIX_LAST) begin
            // Load the write port now so it is valid during WRITE.
            pix_cnt_d = '0;
            state_d   = WRITE;
            waddr_d   = row_cnt_q;
            wdata_d   = row_buf_d;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (row_cnt_q == ROW_LAST) begin
          state_d = DONE;
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
          state_d   = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      row_cnt_q <= '0;
      row_buf_q <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
`ifdef ROW_PACKER_EOL_CHECK_EN
      eol_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      row_cnt_q <= row_cnt_d;
      row_buf_q <= row_buf_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
`ifdef ROW_PACKER_EOL_CHECK_EN
      eol_err_q <= eol_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_image_row_packer.sv
// Self-checking bench for image_row_packer with a row-bank reference model.
module tb_image_row_packer;
  import image_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [PIX_W-1:0]  in_pixel;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ROW_W-1:0]  wdata;
  logic              busy;
  logic              done;
`ifdef ROW_PACKER_EOL_CHECK_EN
  logic              in_eol;
  logic              eol_err;
`endif

  always #5 clk = ~clk;

  image_row_packer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_pixel (in_pixel),
`ifdef ROW_PACKER_EOL_CHECK_EN
    .in_eol   (in_eol),
    .eol_err  (eol_err),
`endif
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int idx   = 0;
  int rdy_viol = 0;

  logic [ROW_W-1:0] exp_bank [ROWS];
  int               exp_cyc  [ROWS];
  logic [ROW_W-1:0] got_data [$];
  int               got_addr [$];
  int               got_cyc  [$];
  int               done_cyc [$];

  // Advance one clock; sample outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (we) begin
      got_data.push_back(wdata);
      got_addr.push_back(int'(waddr));
      got_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
    if (busy && !we && !done && !in_ready) rdy_viol++;
    if (in_ready && (we || !busy)) rdy_viol++;
  endtask

  task automatic clear_log();
    got_data.delete();
    got_addr.delete();
    got_cyc.delete();
    done_cyc.delete();
    rdy_viol = 0;
    idx = 0;
    for (int r = 0; r < ROWS; r++) begin
      exp_bank[r] = '0;
      exp_cyc[r]  = -1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // Start is high in cycle 0; FILL begins in cycle 1.
  task automatic do_start();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [PIX_W-1:0] pix_val(input int mode, input int i);
    int r;
    int c;
    r = i / ROW_PIX;
    c = i % ROW_PIX;
    case (mode)
      0:       return PIX_W'(c);
      1:       return {8'(r), 8'(c), 8'hA5};
      default: return PIX_W'($urandom);
    endcase
  endfunction

  function automatic int diff_pix(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    for (int k = 0; k < ROW_PIX; k++)
      if (a[k*PIX_W +: PIX_W] !== b[k*PIX_W +: PIX_W]) return k;
    return 0;
  endfunction

  // Offer pixels until npix have been accepted in total; model the bank.
  task automatic drive(input int mode, input int npix, input int gap, input int bad_idx);
    int t;
    int guard;
    logic v;
    t = 0;
    guard = 0;
    while (idx < npix && guard < npix * 4 + 400) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = ((t % 4) == 0) || ((t % 4) == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_pixel = pix_val(mode, idx);
`ifdef ROW_PACKER_EOL_CHECK_EN
      in_eol = ((idx % ROW_PIX) == ROW_PIX - 1) ^ (idx == bad_idx);
`endif
      if (v && in_ready) begin
        exp_bank[idx / ROW_PIX][(idx % ROW_PIX) * PIX_W +: PIX_W] = in_pixel;
        if ((idx % ROW_PIX) == ROW_PIX - 1) exp_cyc[idx / ROW_PIX] = cyc + 1;
        idx++;
      end
      tick();
      t++;
      guard++;
    end
    in_valid = 1'b0;
`ifdef ROW_PACKER_EOL_CHECK_EN
    in_eol = 1'b0;
`endif
    n_cmp++;
    if (idx != npix) begin
      n_bad++;
      $display("FAIL drive_timeout accepted=%0d required=%0d (bad_idx %0d)", idx, npix, bad_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0;
`ifdef ROW_PACKER_EOL_CHECK_EN
    in_eol = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (we !== 1'b0)       begin n_bad++; $display("FAIL reset_we got=%b exp=0", we); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_cmp++; if (waddr !== '0)      begin n_bad++; $display("FAIL reset_waddr got=%0d exp=0", waddr); end
    n_cmp++; if (wdata !== '0)      begin n_bad++; $display("FAIL reset_wdata low=%h exp=0", wdata[63:0]); end
`ifdef ROW_PACKER_EOL_CHECK_EN
    n_cmp++; if (eol_err !== 1'b0)  begin n_bad++; $display("FAIL reset_eol_err got=%b exp=0", eol_err); end
`endif
    repeat (4) tick();
    n_cmp++; if (busy !== 1'b0 || we !== 1'b0) begin
      n_bad++; $display("FAIL idle_hold busy=%b we=%b exp=0/0", busy, we);
    end
  endtask

  task automatic test_single_row();
    logic [ROW_W-1:0] d;
    clear_log();
    do_start();
    drive(0, ROW_PIX, 0, -1);
    repeat (3) tick();
    n_cmp++; if (got_cyc.size() != 1) begin n_bad++; $display("FAIL single_we_count got=%0d exp=1", got_cyc.size()); end
    if (got_cyc.size() >= 1) begin
      d = got_data[0];
      n_cmp++; if (got_cyc[0] != ROW_PIX + 1) begin n_bad++; $display("FAIL single_we_cycle got=%0d exp=%0d", got_cyc[0], ROW_PIX + 1); end
      n_cmp++; if (got_addr[0] != 0) begin n_bad++; $display("FAIL single_waddr got=%0d exp=0", got_addr[0]); end
      n_cmp++; if (d[23:0] !== 24'h000000) begin n_bad++; $display("FAIL single_pix0 got=%h exp=000000", d[23:0]); end
      n_cmp++; if (d[3071:3048] !== 24'h00007F) begin n_bad++; $display("FAIL single_pix127 got=%h exp=00007f", d[3071:3048]); end
      n_cmp++; if (d !== exp_bank[0]) begin
        n_bad++; $display("FAIL single_row pixel=%0d got=%h exp=%h", diff_pix(d, exp_bank[0]),
          d[diff_pix(d, exp_bank[0])*PIX_W +: PIX_W], exp_bank[0][diff_pix(d, exp_bank[0])*PIX_W +: PIX_W]);
      end
    end
    n_cmp++; if (rdy_viol != 0) begin n_bad++; $display("FAIL single_in_ready violations=%0d exp=0", rdy_viol); end
    do_reset(1);
  endtask

  task automatic test_back_pressure();
    logic [ROW_W-1:0] ref_row;
    for (int k = 0; k < ROW_PIX; k++) ref_row[k*PIX_W +: PIX_W] = PIX_W'(k);
    clear_log();
    do_start();
    drive(0, 2 * ROW_PIX, 1, -1);
    repeat (3) tick();
    n_cmp++; if (got_cyc.size() != 2) begin n_bad++; $display("FAIL gap_we_count got=%0d exp=2", got_cyc.size()); end
    for (int r = 0; r < 2 && r < got_cyc.size(); r++) begin
      n_cmp++; if (got_data[r] !== ref_row) begin
        n_bad++; $display("FAIL gap_row%0d pixel=%0d got=%h exp=%h", r, diff_pix(got_data[r], ref_row),
          got_data[r][diff_pix(got_data[r], ref_row)*PIX_W +: PIX_W], ref_row[diff_pix(got_data[r], ref_row)*PIX_W +: PIX_W]);
      end
      n_cmp++; if (got_addr[r] != r) begin n_bad++; $display("FAIL gap_addr%0d got=%0d exp=%0d", r, got_addr[r], r); end
      n_cmp++; if (got_cyc[r] != exp_cyc[r]) begin n_bad++; $display("FAIL gap_we_cycle%0d got=%0d exp=%0d", r, got_cyc[r], exp_cyc[r]); end
    end
    n_cmp++; if (rdy_viol != 0) begin n_bad++; $display("FAIL gap_in_ready violations=%0d exp=0", rdy_viol); end
    do_reset(1);
    // Random data with random valid gaps across three rows.
    clear_log();
    do_start();
    drive(2, 3 * ROW_PIX, 2, -1);
    repeat (3) tick();
    n_cmp++; if (got_cyc.size() != 3) begin n_bad++; $display("FAIL rnd_we_count got=%0d exp=3", got_cyc.size()); end
    for (int r = 0; r < 3 && r < got_cyc.size(); r++) begin
      n_cmp++; if (got_data[r] !== exp_bank[r] || got_addr[r] != r || got_cyc[r] != exp_cyc[r]) begin
        n_bad++; $display("FAIL rnd_row%0d addr=%0d/%0d cyc=%0d/%0d pixel=%0d got=%h exp=%h", r, got_addr[r], r,
          got_cyc[r], exp_cyc[r], diff_pix(got_data[r], exp_bank[r]),
          got_data[r][diff_pix(got_data[r], exp_bank[r])*PIX_W +: PIX_W], exp_bank[r][diff_pix(got_data[r], exp_bank[r])*PIX_W +: PIX_W]);
      end
    end
    n_cmp++; if (rdy_viol != 0) begin n_bad++; $display("FAIL rnd_in_ready violations=%0d exp=0", rdy_viol); end
    do_reset(1);
  endtask

  task automatic test_full_frame();
    int bad_rows;
    clear_log();
    do_start();
    drive(1, ROWS * ROW_PIX, 0, -1);
    tick();                      // DONE cycle
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL frame_done_now got=%b exp=1 cyc=%0d", done, cyc); end
    start = 1'b1;                // must be ignored while in DONE
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_in_done_ignored busy=%b exp=0", busy); end
    n_cmp++; if (waddr !== ADDR_W'(ROWS - 1)) begin n_bad++; $display("FAIL waddr_hold got=%0d exp=%0d", waddr, ROWS - 1); end
    n_cmp++; if (wdata !== exp_bank[ROWS-1]) begin n_bad++; $display("FAIL wdata_hold pixel=%0d", diff_pix(wdata, exp_bank[ROWS-1])); end
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_in_idle busy=%b exp=1", busy); end
    n_cmp++; if (got_cyc.size() != ROWS) begin n_bad++; $display("FAIL frame_we_count got=%0d exp=%0d", got_cyc.size(), ROWS); end
    bad_rows = 0;
    for (int r = 0; r < ROWS && r < got_cyc.size(); r++) begin
      n_cmp++;
      if (got_addr[r] != r || got_cyc[r] != (ROW_PIX + 1) * (r + 1) || got_data[r] !== exp_bank[r]) begin
        n_bad++;
        if (bad_rows < 4)
          $display("FAIL frame_row%0d addr=%0d/%0d cyc=%0d/%0d pixel=%0d got=%h exp=%h", r, got_addr[r], r,
            got_cyc[r], (ROW_PIX + 1) * (r + 1), diff_pix(got_data[r], exp_bank[r]),
            got_data[r][diff_pix(got_data[r], exp_bank[r])*PIX_W +: PIX_W], exp_bank[r][diff_pix(got_data[r], exp_bank[r])*PIX_W +: PIX_W]);
        bad_rows++;
      end
    end
    n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL done_count got=%0d exp=1", done_cyc.size()); end
    if (done_cyc.size() >= 1) begin
      n_cmp++; if (done_cyc[0] != ROWS * (ROW_PIX + 1) + 1) begin
        n_bad++; $display("FAIL done_cycle got=%0d exp=%0d", done_cyc[0], ROWS * (ROW_PIX + 1) + 1);
      end
    end
    do_reset(1);
  endtask

  task automatic test_mid_reset();
    int n_before;
    clear_log();
    do_start();
    drive(2, 3 * ROW_PIX + 60, 0, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || we !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_idle busy=%b we=%b in_ready=%b exp=0/0/0", busy, we, in_ready);
    end
    n_cmp++; if (got_cyc.size() != 3) begin n_bad++; $display("FAIL midrst_rows_before got=%0d exp=3", got_cyc.size()); end
    n_before = got_cyc.size();
    in_valid = 1'b1;
    repeat (2 * ROW_PIX) tick();
    in_valid = 1'b0;
    n_cmp++; if (got_cyc.size() != n_before) begin n_bad++; $display("FAIL midrst_no_we got=%0d exp=%0d", got_cyc.size(), n_before); end
    clear_log();
    do_start();
    drive(2, ROW_PIX, 0, -1);
    repeat (2) tick();
    n_cmp++; if (got_cyc.size() != 1) begin n_bad++; $display("FAIL restart_we_count got=%0d exp=1", got_cyc.size()); end
    if (got_cyc.size() >= 1) begin
      n_cmp++; if (got_addr[0] != 0 || got_data[0] !== exp_bank[0]) begin
        n_bad++; $display("FAIL restart_row0 addr=%0d exp=0 pixel=%0d got=%h exp=%h", got_addr[0], diff_pix(got_data[0], exp_bank[0]),
          got_data[0][diff_pix(got_data[0], exp_bank[0])*PIX_W +: PIX_W], exp_bank[0][diff_pix(got_data[0], exp_bank[0])*PIX_W +: PIX_W]);
      end
    end
    do_reset(1);
  endtask

`ifdef ROW_PACKER_EOL_CHECK_EN
  task automatic test_eol_check();
    clear_log();
    do_start();
    drive(0, 50, 0, 50);
    n_cmp++; if (eol_err !== 1'b0) begin n_bad++; $display("FAIL eol_before got=%b exp=0", eol_err); end
    drive(0, 51, 0, 50);
    n_cmp++; if (eol_err !== 1'b1) begin n_bad++; $display("FAIL eol_set got=%b exp=1", eol_err); end
    drive(0, ROWS * ROW_PIX, 0, 50);
    n_cmp++; if (eol_err !== 1'b1) begin n_bad++; $display("FAIL eol_sticky got=%b exp=1", eol_err); end
    tick(); tick();              // DONE, then IDLE
    n_cmp++; if (busy !== 1'b0 || eol_err !== 1'b1) begin n_bad++; $display("FAIL eol_idle busy=%b eol_err=%b exp=0/1", busy, eol_err); end
    clear_log();
    do_start();
    n_cmp++; if (eol_err !== 1'b0) begin n_bad++; $display("FAIL eol_clear_on_start got=%b exp=0", eol_err); end
    drive(0, ROWS * ROW_PIX, 0, -1);
    tick(); tick();
    n_cmp++; if (eol_err !== 1'b0) begin n_bad++; $display("FAIL eol_clean_frame got=%b exp=0", eol_err); end
    n_cmp++; if (done_cyc.size() != 1) begin n_bad++; $display("FAIL eol_frame_done got=%0d exp=1", done_cyc.size()); end
    do_reset(1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_row();
    test_back_pressure();
    test_full_frame();
    test_mid_reset();
`ifdef ROW_PACKER_EOL_CHECK_EN
    test_eol_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_row_packer.md
Name: image_row_packer

Overview:
- Write-side initiator for the image bank (128 rows x 3072 bits).
- Accepts a raster pixel stream of 24-bit pixels over a valid/ready handshake.
- Packs each group of 128 pixels into one 3072-bit row.
- Issues one single-cycle write per row to waddr/we/wdata. After the last row it pulses done.

Parameters:
- PIX_W, 24, bits per pixel.
- ROW_PIX, 128, pixels per bank row; row width ROW_W = PIX_W*ROW_PIX = 3072.
- ROWS, 128, rows per frame.
- ADDR_W, 7, bank address width; must satisfy 2**ADDR_W >= ROWS.

Ports:
- clk, input, 1, single clock. Reset is synchronous and active-high, as below.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a frame; sampled only in IDLE.
- in_valid, input, 1, pixel valid.
- in_pixel, input, PIX_W, pixel data.
- in_ready, output, 1, packer can accept a pixel.
- we, output, 1, bank write enable; one-cycle pulse per row.
- waddr, output, ADDR_W, bank row address.
- wdata, output, ROW_W, packed row.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse after the final row write.

Behaviour:
- Reset values: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0. State=IDLE, pix_cnt=0, row_cnt=0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from in_valid to in_ready.
- IDLE:
  - start=1 -> FILL; pix_cnt=0, row_cnt=0.
  - in_ready=0.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready, in_pixel is stored at row_buf[pix_cnt*PIX_W +: PIX_W]; pixel 0 goes in the LSBs.
  - pix_cnt increments on each accepted pixel.
  - Accepting the pixel with pix_cnt==ROW_PIX-1 -> WRITE, pix_cnt=0.
  - in_valid=0 holds state with no change.
- WRITE (exactly one cycle):
  - we=1, waddr=row_cnt, wdata=row_buf, in_ready=0.
  - If row_cnt==ROWS-1 -> DONE; otherwise row_cnt+1 and -> FILL.
- DONE (one cycle): done=1, then -> IDLE.
- Latency: the last pixel of a row is accepted in cycle N; we is high in cycle N+1. The next pixel can be accepted from cycle N+2.
- Throughput: ROW_PIX+1 cycles per row with continuous valid; a full frame takes ROWS*(ROW_PIX+1)+1 cycles after start.
- wdata holds its last written value between writes. row_buf is not cleared between rows because every word is overwritten.
- start while busy is ignored. start in the same cycle as done (DONE state) is ignored; start is accepted the following cycle in IDLE.
- waddr holds its last value after WRITE.
- rst mid-frame: return to IDLE next edge, discard the partial row, we=0, counters=0.

Optional Feature:
- Macro: ROW_PACKER_EOL_CHECK_EN.
- When defined:
  - Adds input in_eol (1) and output eol_err (1, sticky, reset 0, cleared on accepted start).
  - eol_err is set when an accepted pixel has in_eol=1 and pix_cnt!=ROW_PIX-1.
  - eol_err is also set when in_eol=0 and pix_cnt==ROW_PIX-1.
  - The packing sequence is unchanged.
- When undefined: neither port exists and there is no checking logic.

Decomposition:
- Package image_pkg holds PIX_W, ROW_PIX, ROWS, ADDR_W, ROW_W and a typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} packer_state_t.
- No sub-module. A single module with the state register, two counters and row_buf is natural.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> we, done, busy, in_ready=0; waddr=0; wdata=0.
- Single row with continuous valid, pixel k = 24'h000000+k:
  - we high exactly one cycle after the 128th accept.
  - waddr=0.
  - wdata[23:0]=0, wdata[3071:3048]=24'h00007F.
- Back-pressure gaps: in_valid toggling 1,0,0,1 across row 1 -> wdata identical to the no-gap case; in_ready=0 only during WRITE.
- Full frame, pixel = {row[7:0], col[7:0], 8'hA5}:
  - 128 we pulses with waddr 0..127.
  - done pulses once at cycle 128*129+1 after start.
  - A model bank matches every row.
- Reset mid-frame: rst after 60 pixels of row 3 -> IDLE, no further we. A restart writes row 0 with fresh data.
- ROW_PACKER_EOL_CHECK_EN defined:
  - in_eol=1 on pixel 50 -> eol_err=1 the next cycle, stays set.
  - Next start clears it; a correct frame leaves it 0.
